// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the CPU data-port responder: access size encodings,
// MMIO register offsets and the responder state encoding.
package data_mem_responder_pkg;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  // Offsets relative to the MMIO window base.
  localparam logic [9:0] LED_ADDR = 10'h000;
  localparam logic [9:0] SW_ADDR  = 10'h004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_RESP  = 3'd2,
    ST_MERGE = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/word_ram.sv
// Single-port 32-bit word RAM with one-cycle synchronous read; no reset so it
// maps onto block RAM.
module word_ram #(
  parameter int DEPTH_WORDS = 240
) (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write port and registered read port share the single address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: aligned B/H/W loads and stores against word_ram, sub-word
// stores as read-modify-write, plus the LED/switch MMIO window.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int         DEPTH_WORDS = 240,
  parameter logic [9:0] MMIO_BASE   = 10'h3F0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [9:0]  req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [9:0]  sw_in,
  output logic        resp_ready,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [9:0]  led_out
);

  localparam logic [9:0] LED_FULL = MMIO_BASE + LED_ADDR;
  localparam logic [9:0] SW_FULL  = MMIO_BASE + SW_ADDR;

  state_e      state_r;
  logic [9:0]  addr_r;
  logic [2:0]  size_r;
  logic        we_r;
  logic [31:0] wdata_r;
  logic [31:0] word_r;
  logic [31:0] ram_rdata_s;
  logic [31:0] ram_wdata_s;
  logic [7:0]  ram_addr_s;
  logic        ram_we_s;
  logic        is_mmio_s;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [2:0]  size,
                                               input logic [1:0]  ofs);
    logic [31:0] r;
    case (size)
      SZ_B, SZ_BU: r = {24'h000000, word[{ofs, 3'b000} +: 8]};
      SZ_H, SZ_HU: r = {16'h0000, word[{ofs[1], 4'b0000} +: 16]};
      default:     r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [2:0]  size,
                                             input logic [1:0]  ofs);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_B:    r[{ofs, 3'b000} +: 8]     = wdata[7:0];
      SZ_H:    r[{ofs[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Unsigned sizes are load-only; unknown size codes are rejected outright.
  function automatic logic is_illegal(input logic       we,
                                      input logic [9:0] a,
                                      input logic [2:0] sz);
    logic bad;
    case (sz)
      SZ_B:    bad = 1'b0;
      SZ_BU:   bad = we;
      SZ_H:    bad = a[0];
      SZ_HU:   bad = a[0] | we;
      SZ_W:    bad = (a[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if (a >= MMIO_BASE) begin
      if ((sz != SZ_W) || ((a != LED_FULL) && (a != SW_FULL))) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end else if ({2'b00, a[9:2]} >= 10'(DEPTH_WORDS)) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
    return bad;
  endfunction

  // The read is launched from the live request address during the accept cycle.
  assign ram_addr_s  = (state_r == ST_IDLE) ? req_addr[9:2] : addr_r[9:2];
  assign is_mmio_s   = (addr_r >= MMIO_BASE);
  assign ram_we_s    = rst_n && !is_mmio_s &&
                       ((state_r == ST_WRITE) || (state_r == ST_MERGE));
  assign ram_wdata_s = (state_r == ST_MERGE) ?
                       lane_merge(word_r, wdata_r, size_r, addr_r[1:0]) : wdata_r;
  assign resp_ready  = (state_r == ST_RESP) || (state_r == ST_MERGE) ||
                       (state_r == ST_WRITE) || (state_r == ST_ERR);
  assign resp_err    = (state_r == ST_ERR);

  word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Request FSM with registered load data and LED register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      addr_r     <= 10'h000;
      size_r     <= 3'd0;
      we_r       <= 1'b0;
      wdata_r    <= 32'h00000000;
      word_r     <= 32'h00000000;
      resp_rdata <= 32'h00000000;
      led_out    <= 10'h000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            addr_r  <= req_addr;
            size_r  <= req_size;
            we_r    <= req_we;
            wdata_r <= req_wdata;
            if (is_illegal(req_we, req_addr, req_size)) begin
              state_r <= ST_ERR;
            end else if (req_we && (req_size == SZ_W)) begin
              state_r <= ST_WRITE;
            end else begin
              state_r <= ST_READ;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          word_r  <= ram_rdata_s;
          state_r <= we_r ? ST_MERGE : ST_RESP;
        end
        ST_RESP: begin
          if (is_mmio_s) begin
            resp_rdata <= {22'h000000, (addr_r == LED_FULL) ? led_out : sw_in};
          end else begin
            resp_rdata <= lane_extract(word_r, size_r, addr_r[1:0]);
          end
          state_r <= ST_IDLE;
        end
        ST_WRITE: begin
          if (addr_r == LED_FULL) begin
            led_out <= wdata_r[9:0];
          end
          state_r <= ST_IDLE;
        end
        ST_MERGE: state_r <= ST_IDLE;
        ST_ERR:   state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
